// File: rtl/gpio_pkg.sv
// gpio_pkg: shared LED mode encodings and width helper for the board GPIO block
package gpio_pkg;

    localparam logic [1:0] LED_OFF   = 2'b00;
    localparam logic [1:0] LED_ON    = 2'b01;
    localparam logic [1:0] LED_BLINK = 2'b10;
    localparam logic [1:0] LED_PWM   = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce: one input channel with synchroniser, debounce counter, edge pulses and sticky event
module gpi_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2000000
) (
    input  logic sys0_clk,
    input  logic sys0_rst,
    input  logic gpi_raw,
    input  logic evt_clr,
    output logic gpi_stable,
    output logic gpi_rise,
    output logic gpi_fall,
    output logic evt_pending
);

    localparam int CW = clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    // Synchronise, accept a new level once it has held for DEBOUNCE_CYC cycles, pulse on the change
    always_ff @(posedge sys0_clk) begin
        if (sys0_rst) begin
            sync_q      <= '0;
            cnt         <= '0;
            gpi_stable  <= 1'b0;
            gpi_rise    <= 1'b0;
            gpi_fall    <= 1'b0;
            evt_pending <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], gpi_raw};
            gpi_rise    <= 1'b0;
            gpi_fall    <= 1'b0;
            evt_pending <= (evt_pending & ~evt_clr) | gpi_rise | gpi_fall;
            if (sync_q[1] == gpi_stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt        <= '0;
                gpi_stable <= sync_q[1];
                gpi_rise   <= sync_q[1];
                gpi_fall   <= ~sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_gpio_ctl.sv
// board_gpio_ctl: debounced board inputs with edge events plus off/on/blink/PWM LED drivers
module board_gpio_ctl
    import gpio_pkg::*;
#(
    parameter int N_IN           = 4,
    parameter int N_LED          = 8,
    parameter int DEBOUNCE_CYC   = 2000000,
    parameter int PWM_BITS       = 8,
    parameter int BLINK_DIV_BITS = 24
) (
    input  logic                      sys0_clk,
    input  logic                      sys0_rst,
    input  logic [N_IN-1:0]           gpi_raw,
    output logic [N_IN-1:0]           gpi_stable,
    output logic [N_IN-1:0]           gpi_rise,
    output logic [N_IN-1:0]           gpi_fall,
    output logic [N_IN-1:0]           evt_pending,
    input  logic [N_IN-1:0]           evt_clr,
    input  logic [2*N_LED-1:0]        led_mode,
    input  logic [PWM_BITS*N_LED-1:0] led_duty,
    output logic [N_LED-1:0]          led
);

    logic [PWM_BITS-1:0]       pwm_cnt;
    logic [BLINK_DIV_BITS-1:0] blink_div;
    logic [N_LED-1:0]          led_nxt;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        gpi_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .sys0_clk   (sys0_clk),
            .sys0_rst   (sys0_rst),
            .gpi_raw    (gpi_raw[i]),
            .evt_clr    (evt_clr[i]),
            .gpi_stable (gpi_stable[i]),
            .gpi_rise   (gpi_rise[i]),
            .gpi_fall   (gpi_fall[i]),
            .evt_pending(evt_pending[i])
        );
    end

    // Per-LED drive selected by mode from the shared PWM counter and blink phase
    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < N_LED; i++) begin
            led_nxt[i] = led_mode[2*i +: 2] == LED_ON    ? 1'b1 :
                         led_mode[2*i +: 2] == LED_BLINK ? blink_div[BLINK_DIV_BITS-1] :
                         led_mode[2*i +: 2] == LED_PWM   ? (pwm_cnt < led_duty[PWM_BITS*i +: PWM_BITS]) :
                                                           1'b0;
        end
    end

    // Free-running shared counters keep all LEDs phase-aligned; LED outputs are registered
    always_ff @(posedge sys0_clk) begin
        if (sys0_rst) begin
            pwm_cnt   <= '0;
            blink_div <= '0;
            led       <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_div <= blink_div + 1'b1;
            led       <= led_nxt;
        end
    end

endmodule

// File: tb/tb_board_gpio_ctl.sv
// tb_board_gpio_ctl: directed and randomized checks of board_gpio_ctl against a behavioural model
module tb_board_gpio_ctl;

    localparam int N_IN = 4, N_LED = 8, DC = 8, PB = 4, BB = 4;

    logic                   sys0_clk = 1'b0;
    logic                   sys0_rst = 1'b1;
    logic [N_IN-1:0]        gpi_raw  = '0;
    logic [N_IN-1:0]        evt_clr  = '0;
    logic [2*N_LED-1:0]     led_mode = '0;
    logic [PB*N_LED-1:0]    led_duty = '0;
    logic [N_IN-1:0]        gpi_stable, gpi_rise, gpi_fall, evt_pending;
    logic [N_LED-1:0]       led;

    int total = 0;
    int bad   = 0;

    logic [N_IN-1:0]  m_stable, m_rise, m_fall, m_pend, q0, q1;
    logic [N_LED-1:0] m_led;
    logic             hist [N_IN][DC];
    int               m_cyc;

    board_gpio_ctl #(
        .N_IN(N_IN), .N_LED(N_LED), .DEBOUNCE_CYC(DC), .PWM_BITS(PB), .BLINK_DIV_BITS(BB)
    ) dut (
        .sys0_clk   (sys0_clk),
        .sys0_rst   (sys0_rst),
        .gpi_raw    (gpi_raw),
        .gpi_stable (gpi_stable),
        .gpi_rise   (gpi_rise),
        .gpi_fall   (gpi_fall),
        .evt_pending(evt_pending),
        .evt_clr    (evt_clr),
        .led_mode   (led_mode),
        .led_duty   (led_duty),
        .led        (led)
    );

    always #5 sys0_clk = ~sys0_clk;

    // Advance the model by one clock using the current inputs, then let the DUT take the same edge.
    // A level is accepted once the synchronised input has disagreed with it for DC consecutive samples.
    task automatic step();
        logic sp, diff;
        int   ph;
        if (sys0_rst) begin
            m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0; q0 = '0; q1 = '0;
            m_led = '0; m_cyc = 0;
            for (int c = 0; c < N_IN; c++)
                for (int k = 0; k < DC; k++) hist[c][k] = 1'b0;
        end else begin
            for (int c = 0; c < N_IN; c++) begin
                sp = q1[c];
                q1[c] = q0[c];
                q0[c] = gpi_raw[c];
                m_pend[c] = (m_pend[c] & ~evt_clr[c]) | m_rise[c] | m_fall[c];
                for (int k = DC - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = sp;
                diff = 1'b1;
                for (int k = 0; k < DC; k++) if (hist[c][k] == m_stable[c]) diff = 1'b0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (diff) begin
                    m_stable[c] = sp;
                    m_rise[c]   = sp;
                    m_fall[c]   = ~sp;
                end
            end
            ph = m_cyc % 16;
            for (int i = 0; i < N_LED; i++) begin
                case (led_mode[2*i +: 2])
                    2'b01:   m_led[i] = 1'b1;
                    2'b10:   m_led[i] = (ph >= 8);
                    2'b11:   m_led[i] = (ph < int'(led_duty[PB*i +: PB]));
                    default: m_led[i] = 1'b0;
                endcase
            end
            m_cyc++;
        end
        @(posedge sys0_clk);
        #1;
    endtask

    task automatic test_reset();
        sys0_rst = 1'b1;
        repeat (3) step();
        total++;
        if ({gpi_stable, gpi_rise, gpi_fall, evt_pending, led} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {gpi_stable, gpi_rise, gpi_fall, evt_pending, led});
        end
        sys0_rst = 1'b0;
    endtask

    task automatic test_clean_edge();
        gpi_raw[0] = 1'b1;
        repeat (9) step();
        total++;
        if (gpi_stable[0] !== 1'b0 || gpi_rise[0] !== 1'b0) begin
            bad++;
            $display("FAIL clean_early got stable=%b rise=%b exp 0 0", gpi_stable[0], gpi_rise[0]);
        end
        step();
        total++;
        if (gpi_stable[0] !== 1'b1 || gpi_rise[0] !== 1'b1) begin
            bad++;
            $display("FAIL clean_t10 got stable=%b rise=%b exp 1 1", gpi_stable[0], gpi_rise[0]);
        end
        step();
        total++;
        if (gpi_rise[0] !== 1'b0 || evt_pending[0] !== 1'b1) begin
            bad++;
            $display("FAIL clean_after got rise=%b pend=%b exp 0 1", gpi_rise[0], evt_pending[0]);
        end
        repeat (5) step();
        total++;
        if (evt_pending[0] !== 1'b1) begin
            bad++;
            $display("FAIL clean_sticky got=%b exp=1", evt_pending[0]);
        end
        evt_clr[0] = 1'b1;
        step();
        evt_clr[0] = 1'b0;
        total++;
        if (evt_pending[0] !== 1'b0) begin
            bad++;
            $display("FAIL clean_clr got=%b exp=0", evt_pending[0]);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int b = 0; b < 4; b++) begin
            gpi_raw[1] = (b % 2 == 0);
            repeat (5) begin
                step();
                pulses += int'(gpi_rise[1]) + int'(gpi_fall[1]);
            end
        end
        gpi_raw[1] = 1'b1;
        repeat (9) begin
            step();
            pulses += int'(gpi_rise[1]) + int'(gpi_fall[1]);
        end
        total++;
        if (pulses != 0 || gpi_stable[1] !== 1'b0) begin
            bad++;
            $display("FAIL bounce_quiet got pulses=%0d stable=%b exp 0 0", pulses, gpi_stable[1]);
        end
        step();
        total++;
        if (gpi_rise[1] !== 1'b1 || gpi_stable[1] !== 1'b1) begin
            bad++;
            $display("FAIL bounce_rise got rise=%b stable=%b exp 1 1", gpi_rise[1], gpi_stable[1]);
        end
    endtask

    task automatic test_collision();
        gpi_raw[2] = 1'b1;
        repeat (11) step();
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        total++;
        if (evt_pending[2] !== 1'b0 || gpi_stable[2] !== 1'b1) begin
            bad++;
            $display("FAIL coll_setup got pend=%b stable=%b exp 0 1", evt_pending[2], gpi_stable[2]);
        end
        gpi_raw[2] = 1'b0;
        repeat (10) step();
        total++;
        if (gpi_fall[2] !== 1'b1 || gpi_rise[2] !== 1'b0) begin
            bad++;
            $display("FAIL coll_fall got fall=%b rise=%b exp 1 0", gpi_fall[2], gpi_rise[2]);
        end
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        total++;
        if (evt_pending[2] !== 1'b1) begin
            bad++;
            $display("FAIL coll_set_wins got=%b exp=1", evt_pending[2]);
        end
        step();
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        total++;
        if (evt_pending[2] !== 1'b0) begin
            bad++;
            $display("FAIL coll_second_clr got=%b exp=0", evt_pending[2]);
        end
    endtask

    task automatic test_pwm();
        int duties [3] = '{0, 5, 15};
        int highs, mism;
        led_mode = '0;
        led_mode[1:0] = 2'b11;
        foreach (duties[d]) begin
            led_duty[PB-1:0] = PB'(duties[d]);
            step();
            highs = 0;
            mism  = 0;
            repeat (16) begin
                step();
                highs += int'(led[0]);
                if (led !== m_led) mism++;
            end
            total++;
            if (highs != duties[d] || mism != 0) begin
                bad++;
                $display("FAIL pwm_duty%0d got highs=%0d mism=%0d exp highs=%0d mism=0", duties[d], highs, mism, duties[d]);
            end
        end
    endtask

    task automatic test_blink_on_off();
        int highs, edges, on_bad, off_bad;
        logic prev;
        led_mode = '0;
        led_mode[3:2] = 2'b10;
        led_mode[5:4] = 2'b01;
        led_mode[7:6] = 2'b00;
        step();
        prev = led[1];
        highs = 0; edges = 0; on_bad = 0; off_bad = 0;
        repeat (16) begin
            step();
            highs += int'(led[1]);
            edges += int'(led[1] != prev);
            prev = led[1];
            on_bad  += int'(led[2] !== 1'b1);
            off_bad += int'(led[3] !== 1'b0);
        end
        total++;
        if (highs != 8 || edges != 2) begin
            bad++;
            $display("FAIL blink_wave got highs=%0d edges=%0d exp 8 2", highs, edges);
        end
        total++;
        if (on_bad != 0 || off_bad != 0) begin
            bad++;
            $display("FAIL on_off got on_bad=%0d off_bad=%0d exp 0 0", on_bad, off_bad);
        end
    endtask

    task automatic test_random();
        int b;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                b = $urandom_range(0, N_IN - 1);
                gpi_raw[b] = ~gpi_raw[b];
            end
            evt_clr = ($urandom_range(0, 3) == 0) ? N_IN'($urandom) : '0;
            if (n % 40 == 0) begin
                led_mode = (2*N_LED)'($urandom);
                led_duty = (PB*N_LED)'($urandom);
            end
            step();
            total++;
            if ({gpi_stable, gpi_rise, gpi_fall, evt_pending} !== {m_stable, m_rise, m_fall, m_pend}) begin
                bad++;
                $display("FAIL rand_gpi cyc=%0d got st=%b r=%b f=%b p=%b exp st=%b r=%b f=%b p=%b", n,
                         gpi_stable, gpi_rise, gpi_fall, evt_pending, m_stable, m_rise, m_fall, m_pend);
            end
            total++;
            if (led !== m_led) begin
                bad++;
                $display("FAIL rand_led cyc=%0d got=%b exp=%b", n, led, m_led);
            end
        end
        evt_clr = '0;
    endtask

    task automatic test_reset_mid();
        int rises = 0;
        gpi_raw = '0;
        led_mode = '0;
        led_mode[1:0] = 2'b11;
        led_duty[PB-1:0] = 4'd15;
        repeat (14) step();
        evt_clr = '1;
        step();
        evt_clr = '0;
        gpi_raw[3] = 1'b1;
        repeat (7) begin
            step();
            rises += int'(gpi_rise[3]);
        end
        sys0_rst = 1'b1;
        step();
        total++;
        if ({gpi_stable, gpi_rise, gpi_fall, evt_pending, led} !== '0 || rises != 0) begin
            bad++;
            $display("FAIL rst_mid got outs=%h rises=%0d exp 0 0", {gpi_stable, gpi_rise, gpi_fall, evt_pending, led}, rises);
        end
        sys0_rst = 1'b0;
        repeat (9) begin
            step();
            rises += int'(gpi_rise[3]);
        end
        total++;
        if (rises != 0 || gpi_stable[3] !== 1'b0) begin
            bad++;
            $display("FAIL rst_restart got rises=%0d stable=%b exp 0 0", rises, gpi_stable[3]);
        end
        step();
        total++;
        if (gpi_rise[3] !== 1'b1 || gpi_stable[3] !== 1'b1) begin
            bad++;
            $display("FAIL rst_rise got rise=%b stable=%b exp 1 1", gpi_rise[3], gpi_stable[3]);
        end
        total++;
        if (led !== m_led) begin
            bad++;
            $display("FAIL rst_led got=%b exp=%b", led, m_led);
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_collision();
        test_pwm();
        test_blink_on_off();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
